// File: rtl/fft2d_transposer_if.sv
// Transpose handshake and single-port matrix RAM bus of the 2D FFT transposer.
// swap_count exists only when TRANSPOSER_SWAP_COUNT_EN is defined.
interface fft2d_transposer_if #(
  parameter int LOG_N      = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  transposer_reset;
  logic                  do_transpose;
  logic                  do_bitreversing;
  logic                  done_transpose;
  logic                  transposer_busy;
  logic [2*LOG_N-1:0]    mem_addr;
  logic                  mem_rd_en;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_wr_en;
  logic [DATA_WIDTH-1:0] mem_wr_data;
`ifdef TRANSPOSER_SWAP_COUNT_EN
  logic [2*LOG_N-1:0]    swap_count;
`endif

  modport slave (
`ifdef TRANSPOSER_SWAP_COUNT_EN
    output swap_count,
`endif
    input  transposer_reset, do_transpose, do_bitreversing, mem_rd_data,
    output done_transpose, transposer_busy, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );

  modport master (
`ifdef TRANSPOSER_SWAP_COUNT_EN
    input  swap_count,
`endif
    output transposer_reset, do_transpose, do_bitreversing, mem_rd_data,
    input  done_transpose, transposer_busy, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/fft2d_transposer.sv
// In-place N x N transposer (optional index bit-reversal) over a single-port RAM, read latency 1.
// Optional swap counter output enabled by defining TRANSPOSER_SWAP_COUNT_EN.
module fft2d_transposer #(
  parameter int LOG_N      = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic              extc_base_clock,
  input  logic              extc_sync_reset,
  fft2d_transposer_if.slave tif
);
  localparam int AW = 2*LOG_N;
  localparam logic [AW-1:0] LAST_IDX = {AW{1'b1}};

  typedef enum logic [2:0] {IDLE, SCAN, RD_A, RD_B, LAT, WR_A, WR_B, DONE} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d, addr_q, addr_d, partner;
  logic [LOG_N-1:0]      row, col;
  logic                  mode_q, mode_d;
  logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic                  done_q, done_d, busy_q, busy_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d, reg_a_q, reg_a_d;
  logic                  rst_any;
`ifdef TRANSPOSER_SWAP_COUNT_EN
  logic [AW-1:0]         swap_count_q, swap_count_d;
`endif

  function automatic logic [LOG_N-1:0] bit_rev(input logic [LOG_N-1:0] v);
    logic [LOG_N-1:0] r;
    for (int i = 0; i < LOG_N; i++) r[i] = v[LOG_N-1-i];
    return r;
  endfunction

  assign rst_any = extc_sync_reset | tif.transposer_reset;

  // Partner is a pure function of idx and mode, so it stays valid as B for the whole swap.
  always_comb begin
    row     = idx_q[AW-1:LOG_N];
    col     = idx_q[LOG_N-1:0];
    partner = mode_q ? {bit_rev(col), bit_rev(row)} : {col, row};
  end

  always_ff @(posedge extc_base_clock) begin
    if (rst_any) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mode_q    <= 1'b0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge extc_base_clock) begin
    reg_a_q <= reg_a_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tif.do_transpose) state_d = SCAN;
      SCAN: begin
        if (partner > idx_q)        state_d = RD_A;
        else if (idx_q == LAST_IDX) state_d = DONE;
      end
      RD_A:    state_d = RD_B;
      RD_B:    state_d = LAT;
      LAT:     state_d = WR_A;
      WR_A:    state_d = WR_B;
      WR_B:    state_d = (idx_q == LAST_IDX) ? DONE : SCAN;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    idx_d     = idx_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    reg_a_d   = reg_a_q;
    done_d    = (state_d == DONE);
    busy_d    = (state_d != IDLE) && (state_d != DONE);
    if (state_q == IDLE && state_d == SCAN) begin
      idx_d  = '0;
      mode_d = tif.do_bitreversing;
    end else if (state_d == SCAN) begin
      idx_d = idx_q + 1'b1;
    end
    if (state_q == RD_B) reg_a_d = tif.mem_rd_data;
    case (state_d)
      RD_A: begin addr_d = idx_q;   rd_en_d = 1'b1; end
      RD_B: begin addr_d = partner; rd_en_d = 1'b1; end
      WR_A: begin addr_d = idx_q;   wr_en_d = 1'b1; wr_data_d = tif.mem_rd_data; end
      WR_B: begin addr_d = partner; wr_en_d = 1'b1; wr_data_d = reg_a_q; end
      default: ;
    endcase
  end

`ifdef TRANSPOSER_SWAP_COUNT_EN
  always_comb begin
    swap_count_d = swap_count_q;
    if (state_q == IDLE && state_d == SCAN) swap_count_d = '0;
    else if (state_q == WR_B)               swap_count_d = swap_count_q + 1'b1;
  end

  always_ff @(posedge extc_base_clock) begin
    if (rst_any) swap_count_q <= '0;
    else         swap_count_q <= swap_count_d;
  end

  assign tif.swap_count = swap_count_q;
`endif

  assign tif.done_transpose  = done_q;
  assign tif.transposer_busy = busy_q;
  assign tif.mem_addr        = addr_q;
  assign tif.mem_rd_en       = rd_en_q;
  assign tif.mem_wr_en       = wr_en_q;
  assign tif.mem_wr_data     = wr_data_q;
endmodule

// File: tb/tb_fft2d_transposer.sv
// Bench for fft2d_transposer: a 4x4 and a 32x32 instance, each on its own RAM model,
// checked against an index-permutation reference model.
module tb_fft2d_transposer;
  logic clk = 1'b0;
  logic ext_rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fft2d_transposer_if #(.LOG_N(2), .DATA_WIDTH(32)) s_if();
  fft2d_transposer_if #(.LOG_N(5), .DATA_WIDTH(32)) b_if();

  fft2d_transposer #(.LOG_N(2), .DATA_WIDTH(32)) u_small (
    .extc_base_clock(clk), .extc_sync_reset(ext_rst), .tif(s_if.slave));
  fft2d_transposer #(.LOG_N(5), .DATA_WIDTH(32)) u_big (
    .extc_base_clock(clk), .extc_sync_reset(ext_rst), .tif(b_if.slave));

  logic [31:0] ram_s [16];
  logic [31:0] init_s[16];
  bit          wmark_s[16];
  int          wcnt_s = 0;
  logic        load_s = 1'b0;
  logic [31:0] ram_b [1024];
  logic [31:0] init_b[1024];
  logic        load_b = 1'b0;

  always @(posedge clk) begin
    if (load_s) begin
      for (int i = 0; i < 16; i++) begin ram_s[i] <= init_s[i]; wmark_s[i] <= 1'b0; end
    end else if (s_if.mem_wr_en) begin
      ram_s[s_if.mem_addr]   <= s_if.mem_wr_data;
      wmark_s[s_if.mem_addr] <= 1'b1;
    end
    if (s_if.mem_wr_en) wcnt_s <= wcnt_s + 1;
    if (s_if.mem_rd_en) s_if.mem_rd_data <= ram_s[s_if.mem_addr];
  end

  always @(posedge clk) begin
    if (load_b) begin
      for (int i = 0; i < 1024; i++) ram_b[i] <= init_b[i];
    end else if (b_if.mem_wr_en) begin
      ram_b[b_if.mem_addr] <= b_if.mem_wr_data;
    end
    if (b_if.mem_rd_en) b_if.mem_rd_data <= ram_b[b_if.mem_addr];
  end

  function automatic int rev(input int v, input int logn);
    int r = 0;
    for (int i = 0; i < logn; i++) if (((v >> i) & 1) != 0) r |= 1 << (logn-1-i);
    return r;
  endfunction

  function automatic int partner(input int idx, input int logn, input bit mode);
    int r = idx >> logn;
    int c = idx & ((1 << logn) - 1);
    if (mode) return (rev(c, logn) << logn) | rev(r, logn);
    return (c << logn) | r;
  endfunction

  task automatic run_small(input bit mode, output int lat, output int overlap, output int busy_low);
    s_if.do_bitreversing = mode;
    s_if.do_transpose    = 1'b1;
    lat = -1; overlap = 0; busy_low = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_if.mem_rd_en && s_if.mem_wr_en) overlap++;
      if (s_if.done_transpose) begin lat = k; break; end
      if (!s_if.transposer_busy) busy_low++;
    end
  endtask

  task automatic clear_small();
    s_if.transposer_reset = 1'b1;
    s_if.do_transpose     = 1'b0;
    @(negedge clk);
    s_if.transposer_reset = 1'b0;
  endtask

  task automatic test_reset();
    ext_rst = 1'b1;
    s_if.do_transpose = 1'b1;
    b_if.do_transpose = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_if.done_transpose, s_if.transposer_busy, s_if.mem_addr, s_if.mem_rd_en,
         s_if.mem_wr_en, s_if.mem_wr_data} !== '0) begin
      errors++; $display("FAIL reset_small_outputs got busy=%b done=%b addr=%0d rd=%b wr=%b wdata=%0h expected all 0",
        s_if.transposer_busy, s_if.done_transpose, s_if.mem_addr, s_if.mem_rd_en, s_if.mem_wr_en, s_if.mem_wr_data);
    end
    checks++;
    if ({b_if.done_transpose, b_if.transposer_busy, b_if.mem_addr, b_if.mem_rd_en,
         b_if.mem_wr_en, b_if.mem_wr_data} !== '0) begin
      errors++; $display("FAIL reset_big_outputs got busy=%b done=%b addr=%0d expected all 0",
        b_if.transposer_busy, b_if.done_transpose, b_if.mem_addr);
    end
    b_if.do_transpose = 1'b0;
    ext_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_if.transposer_busy !== 1'b1) begin
      errors++; $display("FAIL start_after_release got busy=%b expected 1", s_if.transposer_busy);
    end
    checks++;
    if (b_if.transposer_busy !== 1'b0) begin
      errors++; $display("FAIL big_idle_after_release got busy=%b expected 0", b_if.transposer_busy);
    end
    clear_small();
    checks++;
    if (s_if.transposer_busy !== 1'b0) begin
      errors++; $display("FAIL clear_after_start got busy=%b expected 0", s_if.transposer_busy);
    end
  endtask

  task automatic test_transpose_small(input bit mode);
    int lat, overlap, busy_low, w0;
    for (int a = 0; a < 16; a++) init_s[a] = a;
    load_s = 1'b1; @(negedge clk); load_s = 1'b0;
    w0 = wcnt_s;
    run_small(mode, lat, overlap, busy_low);
    checks++;
    if (lat !== 46) begin errors++; $display("FAIL small_latency_m%0d got %0d expected 46", mode, lat); end
    checks++;
    if (overlap !== 0 || busy_low !== 0) begin
      errors++; $display("FAIL small_strobes_m%0d got overlap=%0d busy_low=%0d expected 0/0", mode, overlap, busy_low);
    end
    checks++;
    if (wcnt_s - w0 !== 12) begin errors++; $display("FAIL small_writes_m%0d got %0d expected 12", mode, wcnt_s - w0); end
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (ram_s[a] !== init_s[partner(a, 2, mode)]) begin
        errors++; $display("FAIL small_data_m%0d[%0d] got %0d expected %0d", mode, a, ram_s[a], init_s[partner(a, 2, mode)]);
      end
    end
    if (mode) begin
      checks++;
      if (ram_s[1] !== 32'd8 || ram_s[6] !== 32'd6 || ram_s[9] !== 32'd9) begin
        errors++; $display("FAIL bitrev_points got M1=%0d M6=%0d M9=%0d expected 8/6/9", ram_s[1], ram_s[6], ram_s[9]);
      end
      checks++;
      if (wmark_s[0] || wmark_s[6] || wmark_s[9] || wmark_s[15]) begin
        errors++; $display("FAIL fixed_points_written got %b%b%b%b expected 0000", wmark_s[0], wmark_s[6], wmark_s[9], wmark_s[15]);
      end
    end
`ifdef TRANSPOSER_SWAP_COUNT_EN
    checks++;
    if (s_if.swap_count !== 4'd6) begin errors++; $display("FAIL small_swap_count got %0d expected 6", s_if.swap_count); end
`endif
  endtask

  task automatic test_done_hold();
    int drops = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_if.done_transpose !== 1'b1 || s_if.transposer_busy !== 1'b0) drops++;
    end
    checks++;
    if (drops !== 0) begin errors++; $display("FAIL done_hold got %0d bad cycles expected 0", drops); end
    clear_small();
    checks++;
    if (s_if.done_transpose !== 1'b0) begin errors++; $display("FAIL done_clear got %b expected 0", s_if.done_transpose); end
  endtask

  task automatic test_abort();
    int w0, done_seen = 0, busy_seen = 0;
    for (int a = 0; a < 16; a++) init_s[a] = $urandom;
    load_s = 1'b1; @(negedge clk); load_s = 1'b0;
    s_if.do_bitreversing = 1'b0;
    s_if.do_transpose    = 1'b1;
    repeat (20) @(negedge clk);
    s_if.transposer_reset = 1'b1;
    s_if.do_transpose     = 1'b0;
    @(negedge clk);
    checks++;
    if (s_if.transposer_busy !== 1'b0 || s_if.mem_wr_en !== 1'b0 || s_if.mem_rd_en !== 1'b0) begin
      errors++; $display("FAIL abort_outputs got busy=%b wr=%b rd=%b expected 0/0/0",
        s_if.transposer_busy, s_if.mem_wr_en, s_if.mem_rd_en);
    end
    s_if.transposer_reset = 1'b0;
    w0 = wcnt_s;
    repeat (100) begin
      @(negedge clk);
      if (s_if.done_transpose) done_seen++;
      if (s_if.transposer_busy) busy_seen++;
    end
    checks++;
    if (done_seen !== 0 || busy_seen !== 0) begin
      errors++; $display("FAIL abort_quiet got done=%0d busy=%0d expected 0/0", done_seen, busy_seen);
    end
    checks++;
    if (wcnt_s !== w0) begin errors++; $display("FAIL abort_writes got %0d expected %0d", wcnt_s, w0); end
  endtask

  task automatic test_big(input bit mode);
    int lat = -1, overlap = 0, bad = 0, first_bad = -1;
    for (int a = 0; a < 1024; a++) init_b[a] = $urandom;
    load_b = 1'b1; @(negedge clk); load_b = 1'b0;
    b_if.do_bitreversing = mode;
    b_if.do_transpose    = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (k == 3) b_if.do_transpose = 1'b0;
      if (b_if.mem_rd_en && b_if.mem_wr_en) overlap++;
      if (b_if.done_transpose) begin lat = k; break; end
    end
    checks++;
    if (lat !== 3504) begin errors++; $display("FAIL big_latency_m%0d got %0d expected 3504", mode, lat); end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL big_strobe_overlap_m%0d got %0d expected 0", mode, overlap); end
    for (int a = 0; a < 1024; a++)
      if (ram_b[a] !== init_b[partner(a, 5, mode)]) begin bad++; if (first_bad < 0) first_bad = a; end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL big_data_m%0d got %0d bad words (first at %0d) expected 0", mode, bad, first_bad);
    end
`ifdef TRANSPOSER_SWAP_COUNT_EN
    checks++;
    if (b_if.swap_count !== 10'd496) begin errors++; $display("FAIL big_swap_count got %0d expected 496", b_if.swap_count); end
`endif
    b_if.transposer_reset = 1'b1;
    @(negedge clk);
    b_if.transposer_reset = 1'b0;
    checks++;
    if (b_if.done_transpose !== 1'b0) begin errors++; $display("FAIL big_done_clear got %b expected 0", b_if.done_transpose); end
  endtask

  initial begin
    ext_rst = 1'b1;
    s_if.transposer_reset = 1'b0; s_if.do_transpose = 1'b0; s_if.do_bitreversing = 1'b0;
    b_if.transposer_reset = 1'b0; b_if.do_transpose = 1'b0; b_if.do_bitreversing = 1'b0;
    @(negedge clk);
    test_reset();
    test_transpose_small(1'b0);
    test_done_hold();
    test_transpose_small(1'b1);
    clear_small();
    test_abort();
    test_big(1'b0);
    test_big(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
